// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte sources.
// Define UART_TX_ARB_WDOG_EN to add the busy-handshake watchdog and the wdog_err port.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         grant,
  output logic                     TxD_start,
  output logic [7:0]               TxD_data,
  input  logic                     TxD_busy,
  output logic                     tx_done,
  output logic [$clog2(N_REQ)-1:0] active_id
`ifdef UART_TX_ARB_WDOG_EN
  ,
  output logic                     wdog_err
`endif
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT < 1) begin : gBadCfg
    $error("uart_tx_arbiter: N_REQ must be 2..16 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

  state_t           state, stateNxt;
  logic [IW-1:0]    ptr, ptrNxt;
  logic [N_REQ-1:0] grantNxt;
  logic             startNxt, doneNxt;
  logic [7:0]       dataNxt;
  logic [IW-1:0]    idNxt;

`ifdef UART_TX_ARB_WDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wcnt, wcntNxt;
  logic          errNxt;
`endif

  // First pending requester at or above the pointer, wrapping at N_REQ-1.
  logic          found;
  logic [IW-1:0] winner;
  logic [IW:0]   idx;
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(N_REQ)) idx = idx - (IW+1)'(N_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    stateNxt = state;
    ptrNxt   = ptr;
    grantNxt = '0;
    startNxt = 1'b0;
    doneNxt  = 1'b0;
    dataNxt  = TxD_data;
    idNxt    = active_id;
`ifdef UART_TX_ARB_WDOG_EN
    wcntNxt  = wcnt;
    errNxt   = wdog_err;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          dataNxt  = req_data[8*winner +: 8];
          grantNxt = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
          startNxt = 1'b1;
          idNxt    = winner;
          ptrNxt   = (winner == IW'(N_REQ-1)) ? '0 : winner + 1'b1;
          stateNxt = START;
        end
      end
      START: begin
        stateNxt = WAIT_HI;
`ifdef UART_TX_ARB_WDOG_EN
        wcntNxt  = '0;
`endif
      end
      WAIT_HI: begin
        if (TxD_busy) begin
          stateNxt = WAIT_LO;
`ifdef UART_TX_ARB_WDOG_EN
          wcntNxt  = '0;
        end else if (wcnt == CW'(TIMEOUT-1)) begin
          errNxt   = 1'b1;
          stateNxt = IDLE;
        end else begin
          wcntNxt  = wcnt + 1'b1;
`endif
        end
      end
      WAIT_LO: begin
        if (!TxD_busy) begin
          doneNxt  = 1'b1;
          stateNxt = IDLE;
`ifdef UART_TX_ARB_WDOG_EN
        end else if (wcnt == CW'(TIMEOUT-1)) begin
          // Abandon the frame silently; the pointer has already moved on.
          errNxt   = 1'b1;
          stateNxt = IDLE;
        end else begin
          wcntNxt  = wcnt + 1'b1;
`endif
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      TxD_start <= 1'b0;
      TxD_data  <= 8'h00;
      tx_done   <= 1'b0;
      active_id <= '0;
`ifdef UART_TX_ARB_WDOG_EN
      wcnt      <= '0;
      wdog_err  <= 1'b0;
`endif
    end else begin
      state     <= stateNxt;
      ptr       <= ptrNxt;
      grant     <= grantNxt;
      TxD_start <= startNxt;
      TxD_data  <= dataNxt;
      tx_done   <= doneNxt;
      active_id <= idNxt;
`ifdef UART_TX_ARB_WDOG_EN
      wcnt      <= wcntNxt;
      wdog_err  <= errNxt;
`endif
    end
  end

endmodule
